output_drainer: RTL and testbench
=================================

Name: output_drainer

Overview:
- Reader/serializer at the far end of the filtered-output collector.
- Accepts one complete interpolated block: 8 rows x 8 cols x 5 fractional positions x 8 bits = 40 words of 64 bits, 2560 bits total.
- Streams the block back out one 64-bit word per cycle, in fill order, under a valid/ready handshake.
- Feeds the downstream writeback/memory interface; provides backpressure toward the collector.

Parameters:
- WORD_W, 64, bits per output word (8 pixels x 8 bits).
- NUM_WORDS, 40, words per block.
- IDX_W, 6, width of word index; must satisfy 2^IDX_W >= NUM_WORDS.

Ports:
- clock  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- flush_L  input  1  synchronous active-low abort; drops any block in flight.
- blk_valid  input  1  upstream block available on blk_in.
- blk_ready  output  1  drainer can accept a block.
- blk_in  input  WORD_W*NUM_WORDS  block; word k = blk_in[k*WORD_W +: WORD_W].
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts word this cycle.
- out_data  output  WORD_W  current word.
- out_idx  output  IDX_W  sequence number of current word, 0 = first emitted.
- out_last  output  1  current word is the final word of the block.
- busy  output  1  block held and not yet fully drained.

Behaviour:
- Reset (async, reset_L low): state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, held block cleared. blk_ready=1 once reset_L is high.
- States: IDLE, SEND.
- IDLE:
  - blk_ready=1, out_valid=0.
  - blk_valid&&blk_ready captures blk_in into the block buffer and goes to SEND.
  - The first word is presented registered on the next rising edge: 1-cycle latency, out_idx=0.
- SEND:
  - blk_ready=0, out_valid=1.
  - Emission order is most-significant word first: idx i outputs word NUM_WORDS-1-i. idx 0 = blk_in[2559:2496]. This matches the collector's shift order, so the first pixel row produced is the first emitted.
  - out_valid&&out_ready advances to the next word. With out_ready stuck high, the block drains in exactly NUM_WORDS cycles.
  - With out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable; valid is never withdrawn.
  - out_last=1 iff out_idx==NUM_WORDS-1.
  - Handshake on the last word returns to IDLE; out_valid=0 on the following cycle.
- busy = (state==SEND).
- Index counter saturates logically at NUM_WORDS-1 and never wraps mid-block; unused index codes are unreachable.
- flush_L low at a clock edge forces IDLE, out_valid=0, out_idx=0 and ignores blk_valid in that cycle. flush has priority over every handshake.
- Simultaneous flush and last-word handshake: the flush wins; the downstream still counts the word as transferred.
- Reset mid-block: the block is discarded with no partial completion signalled.
- Held buffer contents in IDLE are don't-care, but out_data retains its last value.

Optional Feature:
- Macro: OUTPUT_DRAINER_PREFETCH_EN.
- Enabled:
  - Adds a second block buffer. blk_ready=1 in SEND whenever the second buffer is empty, and a block captured there is queued.
  - After the last-word handshake, the queued block's idx 0 appears on the next edge (out_valid stays 1, zero bubble).
  - Accept and last-word handshake in the same cycle are both honoured.
  - flush clears both buffers.
- Disabled: single buffer; one idle cycle between blocks minimum (IDLE visit).

Decomposition:
- Shared package output_pkg holds WORD_W, NUM_WORDS, IDX_W, BLK_W=WORD_W*NUM_WORDS and the drainer state enum (IDLE, SEND). The same package is used by the collector side.
- One sub-module, output_drain_buf: BLK_W storage with load enable plus word-select mux indexed by out_idx. It is instantiated twice when prefetch is enabled.

Test Plan:
- Word order: block with word k = {8{k[7:0]}}, out_ready=1 -> 40 words on consecutive cycles with data 39,38,...,0 replicated; out_idx 0..39; out_last only on idx 39; out_valid drops on cycle 41.
- Backpressure: out_ready low for 5 cycles at idx 7 -> out_data/out_idx frozen at idx 7 throughout; no word lost or duplicated; total 45 cycles.
- Back-to-back: blk_valid held high across two blocks -> without macro, one-cycle gap between idx 39 and next idx 0. With OUTPUT_DRAINER_PREFETCH_EN, zero gap and second block accepted during the first block's SEND.
- Flush: flush_L low at idx 20 -> next cycle out_valid=0, blk_ready=1, busy=0; a fresh block restarts at idx 0.
- Async reset at idx 12: reset_L low between edges -> outputs zero immediately; after release, IDLE with blk_ready=1 and no residual words.
- Accept gating: blk_valid pulsed during SEND (macro off) -> ignored; the block drains unchanged.

Source files
------------

// File: rtl/output_pkg.sv
// output_pkg: shared geometry and drainer state for the filtered-output collector/drainer pair
package output_pkg;
  localparam int WORD_W = 64;
  localparam int NUM_WORDS = 40;
  localparam int IDX_W = 6;
  localparam int BLK_W = WORD_W * NUM_WORDS;
  typedef enum logic {IDLE, SEND} drain_state_t;
endpackage

// File: rtl/output_drain_buf.sv
// output_drain_buf: one block of storage with load enable and MS-word-first word select
module output_drain_buf
  import output_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset_L,
  input  logic                                load,
  input  logic [BLK_W-1:0]                    blk_in,
  input  logic [IDX_W-1:0]                    idx,
  output logic [WORD_W-1:0]                   word
);
  logic [NUM_WORDS-1:0][WORD_W-1:0] blk;
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) blk <= '0;
    else if (load) blk <= blk_in;
  assign word = blk[IDX_W'(NUM_WORDS - 1) - idx];
endmodule

// File: rtl/output_drainer.sv
// output_drainer: streams a held 40-word block out MS word first; OUTPUT_DRAINER_PREFETCH_EN queues a second block for zero-bubble drain
module output_drainer
  import output_pkg::*;
(
  input  logic               clock,
  input  logic               reset_L,
  input  logic               flush_L,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLK_W-1:0]   blk_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);
  drain_state_t state;
  logic fire, done, accept;
  logic [IDX_W-1:0] nxt_idx;
  logic [WORD_W-1:0] head_in;
  assign out_valid = state == SEND;
  assign busy = out_valid;
  assign out_last = out_idx == IDX_W'(NUM_WORDS - 1);
  assign fire = out_valid && out_ready;
  assign done = fire && out_last;
  assign accept = blk_valid && blk_ready && flush_L;
  assign nxt_idx = out_last ? out_idx : out_idx + 1'b1;
  assign head_in = blk_in[BLK_W-1 -: WORD_W];
`ifdef OUTPUT_DRAINER_PREFETCH_EN
  logic cur, q_full;
  logic [WORD_W-1:0] word [2];
  assign blk_ready = !out_valid || !q_full;
  // IDLE loads the active buffer, SEND loads the other one as the queued block
  for (genvar b = 0; b < 2; b++) begin : g_buf
    output_drain_buf u_buf (
      .clock,
      .reset_L,
      .load  (accept && ((cur ^ out_valid) == 1'(b))),
      .blk_in,
      .idx   (cur == 1'(b) ? nxt_idx : IDX_W'(0)),
      .word  (word[b])
    );
  end
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      state <= IDLE;
      out_idx <= '0;
      out_data <= '0;
      cur <= 1'b0;
      q_full <= 1'b0;
    end else if (!flush_L) begin
      state <= IDLE;
      out_idx <= '0;
      q_full <= 1'b0;
    end else if (!out_valid) begin
      if (accept) begin
        state <= SEND;
        out_data <= head_in;
      end
    end else if (done && (q_full || accept)) begin
      cur <= !cur;
      q_full <= 1'b0;
      out_idx <= '0;
      out_data <= q_full ? word[!cur] : head_in;
    end else if (done) begin
      state <= IDLE;
      out_idx <= '0;
    end else begin
      if (accept) q_full <= 1'b1;
      if (fire) begin
        out_idx <= nxt_idx;
        out_data <= word[cur];
      end
    end
`else
  logic [WORD_W-1:0] word;
  assign blk_ready = !out_valid;
  output_drain_buf u_buf (
    .clock,
    .reset_L,
    .load  (accept),
    .blk_in,
    .idx   (nxt_idx),
    .word
  );
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      state <= IDLE;
      out_idx <= '0;
      out_data <= '0;
    end else if (!flush_L) begin
      state <= IDLE;
      out_idx <= '0;
    end else if (!out_valid) begin
      if (accept) begin
        state <= SEND;
        out_data <= head_in;
      end
    end else if (done) begin
      state <= IDLE;
      out_idx <= '0;
    end else if (fire) begin
      out_idx <= nxt_idx;
      out_data <= word;
    end
`endif
endmodule

// File: tb/tb_output_drainer.sv
// tb_output_drainer: scenario table, back-to-back, async reset and random traffic against a word-queue model
module tb_output_drainer;
  import output_pkg::*;
  logic clock = 1'b0, reset_L = 1'b0, flush_L = 1'b1, blk_valid = 1'b0, out_ready = 1'b0;
  logic [BLK_W-1:0] blk_in = '0;
  logic blk_ready, out_valid, out_last, busy;
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  int tests = 0, fails = 0, hs = 0, vcyc = 0;
  logic seen_v;
  logic [WORD_W-1:0] exp_q[$];
  typedef struct {
    string name;
    bit    ramp;
    int    stall_at, stall_len, flush_at, pulse_at;
    int    exp_hs, exp_vcyc;
  } scen_t;
  scen_t tbl[7];

  always #5 clock = ~clock;

  output_drainer dut (
    .clock(clock), .reset_L(reset_L), .flush_L(flush_L), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_in(blk_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rand_blk();
    for (int k = 0; k < NUM_WORDS; k++) blk_in[k*WORD_W +: WORD_W] = {$urandom, $urandom};
  endtask

  // One cycle: compare against the model mid-cycle, then advance the model at the edge
  task automatic tick();
    @(negedge clock);
    chk("valid", out_valid, exp_q.size() != 0);
    chk("blk_ready", blk_ready, exp_q.size() == 0);
    chk("busy", busy, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("data", out_data, exp_q[0]);
      chk("idx", out_idx, NUM_WORDS - exp_q.size());
      chk("last", out_last, exp_q.size() == 1);
    end
    seen_v = out_valid;
    if (out_valid) vcyc++;
    if (out_valid && out_ready) hs++;
    @(posedge clock);
    if (!flush_L) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (blk_valid) for (int k = NUM_WORDS - 1; k >= 0; k--) exp_q.push_back(blk_in[k*WORD_W +: WORD_W]);
    end else if (out_ready) void'(exp_q.pop_front());
    #1;
  endtask

  task automatic run(input scen_t s);
    int stalled = 0, cur;
    if (s.ramp) for (int k = 0; k < NUM_WORDS; k++) blk_in[k*WORD_W +: WORD_W] = {8{8'(k)}};
    else rand_blk();
    blk_valid = 1'b1; out_ready = 1'b1; flush_L = 1'b1;
    tick();
    blk_valid = 1'b0;
    hs = 0; vcyc = 0;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      cur = NUM_WORDS - exp_q.size();
      out_ready = !(cur == s.stall_at && stalled < s.stall_len);
      if (!out_ready) stalled++;
      flush_L = !(cur == s.flush_at);
      blk_valid = cur == s.pulse_at;
      if (blk_valid) rand_blk();
      tick();
    end
    flush_L = 1'b1; blk_valid = 1'b0;
    chk({s.name, " drained"}, exp_q.size() == 0, 1'b1);
    chk({s.name, " words"}, hs, s.exp_hs);
    chk({s.name, " cycles"}, vcyc, s.exp_vcyc);
    tick();
  endtask

  task automatic back_to_back();
    int acc = 0, first = -1, last = -1, cnt = 0;
    rand_blk();
    blk_valid = 1'b1; out_ready = 1'b1; flush_L = 1'b1;
    for (int n = 0; n < 120 && !(acc == 2 && exp_q.size() == 0); n++) begin
      if (blk_valid && exp_q.size() == 0) acc++;
      tick();
      if (acc == 1 && blk_valid) rand_blk();
      if (acc == 2) blk_valid = 1'b0;
      if (seen_v) begin
        if (first < 0) first = n;
        last = n;
        cnt++;
      end
    end
    chk("b2b valid cycles", cnt, 2 * NUM_WORDS);
    chk("b2b gap", last - first + 1 - cnt, 1);
  endtask

  task automatic reset_mid();
    rand_blk();
    blk_valid = 1'b1; out_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int n = 0; n < 60 && (NUM_WORDS - exp_q.size()) != 12; n++) tick();
    chk("rst reached idx 12", out_idx, 12);
    #3 reset_L = 1'b0;
    #1;
    chk("rst valid", out_valid, 1'b0);
    chk("rst data", out_data, '0);
    chk("rst idx", out_idx, '0);
    chk("rst last", out_last, 1'b0);
    chk("rst busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clock);
    #2 reset_L = 1'b1;
    @(posedge clock);
    #1;
    for (int n = 0; n < 4; n++) tick();
  endtask

  initial begin
    tbl[0] = '{"order", 1'b1, -1, 0, -1, -1, 40, 40};
    tbl[1] = '{"backpressure", 1'b0, 7, 5, -1, -1, 40, 45};
    tbl[2] = '{"flush20", 1'b0, -1, 0, 20, -1, 21, 21};
    tbl[3] = '{"flush_last", 1'b0, -1, 0, 39, -1, 40, 40};
    tbl[4] = '{"stall_last", 1'b0, 39, 3, -1, -1, 40, 43};
    tbl[5] = '{"stall_first", 1'b0, 0, 2, -1, -1, 40, 42};
    tbl[6] = '{"gated", 1'b0, -1, 0, -1, 10, 40, 40};
    #2;
    chk("reset valid", out_valid, 1'b0);
    chk("reset data", out_data, '0);
    chk("reset idx", out_idx, '0);
    chk("reset last", out_last, 1'b0);
    chk("reset busy", busy, 1'b0);
    #10 reset_L = 1'b1;
    @(posedge clock);
    #1;
    tick();
    foreach (tbl[i]) run(tbl[i]);
    back_to_back();
    tick();
    reset_mid();
    for (int n = 0; n < 1500; n++) begin
      blk_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      flush_L = $urandom_range(0, 49) != 0;
      if (blk_valid && exp_q.size() == 0) rand_blk();
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
